uart_sol_sel_ctrl: RTL and testbench

Serial-over-LAN select controller that sits directly upstream of the SOL UART mux. It synchronizes and debounces the BMC select GPIOs and holds the mux select steady until the currently routed UART path has been idle long enough to switch without cutting a character. It then disables the mux for a guard gap and enables the new route. Its outputs drive the mux's select pair and its active-low enable/reset input.

---
 rtl/uart_sol_sel_ctrl_pkg.sv | 19 +
 rtl/sol_sel_debounce.sv | 48 ++++
 rtl/uart_sol_sel_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_sol_sel_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_sol_sel_ctrl_pkg.sv
// Shared encodings for the SOL UART mux select controller: FSM states and
// the 2-bit select codes driven onto the mux select pair.
package uart_sol_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UART0_A = 2'b00,
        UART1_A = 2'b01,
        UART0_B = 2'b10,
        UART1_B = 2'b11
    } sol_sel_t;

endpackage

// File: rtl/sol_sel_debounce.sv
// Synchronizes the BMC select GPIO pair and publishes it as sel_stable only
// after it has held the same value for DEBOUNCE_CYC consecutive cycles.
module sol_sel_debounce #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] gpio,
    output logic [1:0] sel_stable,
    output logic       sel_load
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DB_SAT  = CNT_W'(DEBOUNCE_CYC);

    logic [1:0]       sync1;
    logic [1:0]       cand;
    logic [CNT_W-1:0] cnt_db;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            cand       <= '0;
            cnt_db     <= '0;
            sel_stable <= '0;
            sel_load   <= 1'b0;
        end else begin
            sync1    <= gpio;
            cand     <= sync1;
            sel_load <= 1'b0;
            // sync1 differing from cand means cand changes on this edge.
            if (sync1 != cand) begin
                cnt_db <= '0;
            end else begin
                if (cnt_db != DB_SAT) begin
                    cnt_db <= cnt_db + 1'b1;
                end
                if (cnt_db == DB_LAST) begin
                    sel_stable <= cand;
                    sel_load   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_sol_sel_ctrl.sv
// SOL mux select controller: waits for the routed UART to go idle, gaps the
// mux disabled, then enables the new route. Optional macro UART_SOL_TIMEOUT_EN.
module uart_sol_sel_ctrl
    import uart_sol_sel_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int IDLE_CYC     = 2400,
    parameter int GAP_CYC      = 256,
    parameter int TIMEOUT_CYC  = 65535,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bmc_gpio24,
    input  logic       bmc_gpio25,
    input  logic       mon_bmc_tx,
    input  logic       mon_host_tx,
    output logic [1:0] sol_sel,
    output logic       sol_en,
    output logic       switch_busy,
    output logic       drain_timeout
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    logic [1:0]       sel_stable;
    logic             sel_load;
    sol_sel_t         sel_cur;
    logic [1:0]       mon_sync1;
    logic [1:0]       mon_sync2;
    logic [CNT_W-1:0] cnt_idle;
    logic             line_idle;

    state_t           state, state_next;
    sol_sel_t         target, target_next;
    sol_sel_t         sel_q, sel_next;
    logic             en_next;
    logic             to_pulse;
    logic             go_gap;
    logic [CNT_W-1:0] cnt_gap, gap_next;
`ifdef UART_SOL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_to, to_next;
`endif

    sol_sel_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .gpio       ({bmc_gpio24, bmc_gpio25}),
        .sel_stable (sel_stable),
        .sel_load   (sel_load)
    );

    assign sel_cur   = sol_sel_t'(sel_stable);
    assign line_idle = (cnt_idle >= IDLE_LAST);
    assign sol_sel   = sel_q;

    // Idle lines sit high, so their synchronizers reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mon_sync1 <= 2'b11;
            mon_sync2 <= 2'b11;
            cnt_idle  <= '0;
        end else begin
            mon_sync1 <= {mon_bmc_tx, mon_host_tx};
            mon_sync2 <= mon_sync1;
            if (&mon_sync2) begin
                if (cnt_idle != IDLE_LAST) begin
                    cnt_idle <= cnt_idle + 1'b1;
                end
            end else begin
                cnt_idle <= '0;
            end
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        target_next = target;
        sel_next    = sel_q;
        en_next     = sol_en;
        gap_next    = cnt_gap;
        to_pulse    = 1'b0;
        go_gap      = 1'b0;
`ifdef UART_SOL_TIMEOUT_EN
        to_next     = cnt_to;
`endif
        unique case (state)
            INIT: begin
                if (sel_load) begin
                    target_next = sel_cur;
                    go_gap      = 1'b1;
                end
            end
            ROUTE: begin
                if (sel_cur != sel_q) begin
                    target_next = sel_cur;
                    state_next  = DRAIN;
`ifdef UART_SOL_TIMEOUT_EN
                    to_next     = '0;
`endif
                end
            end
            DRAIN: begin
                if (sel_cur == sel_q) begin
                    state_next = ROUTE;
                end else begin
                    target_next = sel_cur;
                    // An idle line wins over a coincident timeout, without a pulse.
                    if (line_idle) begin
                        go_gap = 1'b1;
`ifdef UART_SOL_TIMEOUT_EN
                    end else if (cnt_to == TO_LAST) begin
                        go_gap   = 1'b1;
                        to_pulse = 1'b1;
                    end else begin
                        to_next = cnt_to + 1'b1;
`endif
                    end
                end
            end
            GAP: begin
                if (cnt_gap == GAP_LAST) begin
                    state_next = ROUTE;
                    en_next    = 1'b1;
                end else begin
                    gap_next = cnt_gap + 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
        // The select only moves on the edge that drops the enable.
        if (go_gap) begin
            state_next = GAP;
            sel_next   = target_next;
            en_next    = 1'b0;
            gap_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= INIT;
            target        <= UART0_A;
            sel_q         <= UART0_A;
            sol_en        <= 1'b0;
            switch_busy   <= 1'b1;
            drain_timeout <= 1'b0;
            cnt_gap       <= '0;
`ifdef UART_SOL_TIMEOUT_EN
            cnt_to        <= '0;
`endif
        end else begin
            state         <= state_next;
            target        <= target_next;
            sel_q         <= sel_next;
            sol_en        <= en_next;
            switch_busy   <= (state_next != ROUTE);
            drain_timeout <= to_pulse;
            cnt_gap       <= gap_next;
`ifdef UART_SOL_TIMEOUT_EN
            cnt_to        <= to_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_sol_sel_ctrl.sv
// Directed bench for uart_sol_sel_ctrl with small cycle constants; covers
// startup, clean switches, glitches, line activity, drain timeout and reset.
module tb_uart_sol_sel_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bmc_gpio24 = 1'b0;
    logic       bmc_gpio25 = 1'b0;
    logic       mon_bmc_tx = 1'b1;
    logic       mon_host_tx = 1'b1;
    logic [1:0] sol_sel;
    logic       sol_en;
    logic       switch_busy;
    logic       drain_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_sol_sel_ctrl #(
        .DEBOUNCE_CYC (8),
        .IDLE_CYC     (20),
        .GAP_CYC      (4),
        .TIMEOUT_CYC  (100),
        .CNT_W        (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bmc_gpio24    (bmc_gpio24),
        .bmc_gpio25    (bmc_gpio25),
        .mon_bmc_tx    (mon_bmc_tx),
        .mon_host_tx   (mon_host_tx),
        .sol_sel       (sol_sel),
        .sol_en        (sol_en),
        .switch_busy   (switch_busy),
        .drain_timeout (drain_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gpio(input logic [1:0] v);
        {bmc_gpio24, bmc_gpio25} = v;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s, input logic e,
                              input logic b, input logic t);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {sol_sel, sol_en, switch_busy, drain_timeout};
        exp = {s, e, b, t};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed sel/en/busy/to=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_route(input string tag, input logic [1:0] s, input int budget);
        int k;
        k = 0;
        while (!(sol_en === 1'b1 && switch_busy === 1'b0 && sol_sel === s) && k < budget) begin
            tick();
            k++;
        end
        expect_out(tag, s, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Startup with GPIO=10 and idle lines.
        set_gpio(2'b10);
        #2 reset = 1'b0;
        repeat (3) tick();
        expect_out("reset_vals", 2'b00, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            expect_out($sformatf("t1_init_e%0d", e), 2'b00, 1'b0, 1'b1, 1'b0);
        end
        for (int e = 11; e <= 14; e++) begin
            tick();
            expect_out($sformatf("t1_gap_e%0d", e), 2'b10, 1'b0, 1'b1, 1'b0);
        end
        tick();
        expect_out("t1_route", 2'b10, 1'b1, 1'b0, 1'b0);

        // Move to route 00.
        set_gpio(2'b00);
        wait_route("t2_route00", 2'b00, 60);

        // Clean switch 00 -> 01 with idle lines: exact cycle timeline.
        set_gpio(2'b01);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e <= 10)      expect_out($sformatf("t3_route_e%0d", e), 2'b00, 1'b1, 1'b0, 1'b0);
            else if (e == 11) expect_out("t3_drain", 2'b00, 1'b1, 1'b1, 1'b0);
            else if (e <= 15) expect_out($sformatf("t3_gap_e%0d", e), 2'b01, 1'b0, 1'b1, 1'b0);
            else              expect_out("t3_route01", 2'b01, 1'b1, 1'b0, 1'b0);
        end

        // Back to 00, then a 5-cycle glitch to 11 must be ignored.
        set_gpio(2'b00);
        wait_route("t4_route00", 2'b00, 60);
        set_gpio(2'b11);
        for (int e = 1; e <= 5; e++) begin
            tick();
            expect_out($sformatf("t5_glitch_e%0d", e), 2'b00, 1'b1, 1'b0, 1'b0);
        end
        set_gpio(2'b00);
        for (int e = 6; e <= 35; e++) begin
            tick();
            expect_out($sformatf("t5_after_e%0d", e), 2'b00, 1'b1, 1'b0, 1'b0);
        end

        // Request 01 while host line toggles every 10 cycles for 60 cycles.
        set_gpio(2'b01);
        for (int c = 0; c < 60; c++) begin
            mon_host_tx = ((c / 10) % 2) != 0;
            tick();
            expect_out($sformatf("t6_busy_e%0d", c + 1), 2'b00, 1'b1, (c + 1) >= 11, 1'b0);
        end
        mon_host_tx = 1'b1;
        for (int e = 61; e <= 71; e++) begin
            tick();
            expect_out($sformatf("t6_wait_e%0d", e), 2'b00, 1'b1, 1'b1, 1'b0);
        end
        tick();
        expect_out("t6_gap", 2'b01, 1'b0, 1'b1, 1'b0);
        wait_route("t6_route01", 2'b01, 20);

        // Request 10 with the BMC line stuck low.
        set_gpio(2'b10);
        mon_bmc_tx = 1'b0;
`ifdef UART_SOL_TIMEOUT_EN
        for (int e = 1; e <= 110; e++) begin
            tick();
            expect_out($sformatf("t7_drain_e%0d", e), 2'b01, 1'b1, e >= 11, 1'b0);
        end
        tick();
        expect_out("t7_timeout", 2'b10, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("t7_pulse_end", 2'b10, 1'b0, 1'b1, 1'b0);
`else
        for (int e = 1; e <= 150; e++) begin
            tick();
            expect_out($sformatf("t7_hold_e%0d", e), 2'b01, 1'b1, e >= 11, 1'b0);
        end
`endif
        mon_bmc_tx = 1'b1;
        repeat (30) tick();
        wait_route("t7_route10", 2'b10, 40);

        // Switch to 11, assert reset in the middle of GAP.
        set_gpio(2'b11);
        for (int e = 1; e <= 11; e++) begin
            tick();
            expect_out($sformatf("t8_pre_e%0d", e), 2'b10, 1'b1, e >= 11, 1'b0);
        end
        tick();
        expect_out("t8_gap_e12", 2'b11, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("t8_gap_e13", 2'b11, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        expect_out("t8_async_rst", 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        expect_out("t8_rst_hold", 2'b00, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            expect_out($sformatf("t8_init_e%0d", e), 2'b00, 1'b0, 1'b1, 1'b0);
        end
        for (int e = 11; e <= 14; e++) begin
            tick();
            expect_out($sformatf("t8_regap_e%0d", e), 2'b11, 1'b0, 1'b1, 1'b0);
        end
        tick();
        expect_out("t8_route11", 2'b11, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
